udp_rx: RTL and testbench

Receive-side UDP de-encapsulator and the counterpart of `udp_tx`. It accepts an 8-bit AXI-Stream carrying the IPv4 payload (the UDP header followed by UDP payload) and parses the 8-byte header into parallel fields. The fields are presented on a header valid/ready channel, and the payload is then forwarded on an AXI-Stream trimmed to the UDP length. It sits between the IP receive block and the application/socket layer.

---
 rtl/udp_pkg.sv | 21 ++
 rtl/axis_reg_slice.sv | 52 +++++
 rtl/udp_rx.sv | 172 +++++++++++++++++
 tb/tb_udp_rx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared UDP receive types: header layout (big-endian wire order, src first) and parser states.
package udp_pkg;

    localparam int UDP_HDR_BYTES = 8;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] checksum;
    } udp_hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HDR_OUT,
        PAYLOAD,
        DRAIN
    } udp_rx_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream register stage: one cycle latency, full throughput.
// Upstream ready is !full || downstream ready; the held beat is stable until taken.
module axis_reg_slice #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_trdy,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_trdy
);

    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  vld_q, vld_d;
    logic                  last_q, last_d;

    assign s_trdy   = !vld_q || m_trdy;
    assign m_tdata  = dat_q;
    assign m_tvalid = vld_q;
    assign m_tlast  = last_q;

    always_comb begin
        dat_d  = dat_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (s_tvalid && s_trdy) begin
            dat_d  = s_tdata;
            last_d = s_tlast;
            vld_d  = 1'b1;
        end else if (m_trdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dat_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            dat_q  <= dat_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/udp_rx.sv
// UDP de-encapsulator: header fields valid the cycle after byte 7, payload one cycle after acceptance.
// Input stalls while the header waits for its handshake and while the payload stage is full.
module udp_rx
    import udp_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_trdy,
    output logic                      m_udp_hdr_tvalid,
    input  logic                      m_udp_hdr_trdy,
    output logic [15:0]               m_udp_src_port,
    output logic [15:0]               m_udp_dst_port,
    output logic [15:0]               m_udp_length,
    output logic [15:0]               m_udp_hdr_checksum,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_trdy,
    output logic                      o_hdr_err,
    output logic                      o_len_err
);

    localparam logic [15:0] HDR_LEN  = 16'(UDP_HDR_BYTES);
    localparam logic [2:0]  LAST_IDX = 3'(UDP_HDR_BYTES - 1);

    udp_rx_state_t state_q, state_d;
    udp_hdr_t      hdr_q, hdr_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [15:0]   pcnt_q, pcnt_d;
    logic          ended_q, ended_d;
    logic          rdy_en_q, rdy_en_d;

    logic [$bits(udp_hdr_t)-1:0] hdr_vec;
    logic [2:0]                  byte_idx;
    logic                        accept;
    logic                        sl_in_vld, sl_in_last, sl_in_rdy;
    logic                        hdr_err, len_err;

    axis_reg_slice #(
        .DATA_WIDTH(AXI_DATA_WIDTH)
    ) u_pay_slice (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .s_tdata  (s_axis_tdata),
        .s_tvalid (sl_in_vld),
        .s_tlast  (sl_in_last),
        .s_trdy   (sl_in_rdy),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .m_tlast  (m_axis_tlast),
        .m_trdy   (m_axis_trdy)
    );

    always_comb begin
        case (state_q)
            HDR_OUT: s_axis_trdy = 1'b0;
            PAYLOAD: s_axis_trdy = sl_in_rdy;
            default: s_axis_trdy = rdy_en_q;
        endcase
    end

    assign accept = s_axis_tvalid && s_axis_trdy;

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        bcnt_d     = bcnt_q;
        pcnt_d     = pcnt_q;
        ended_d    = ended_q;
        rdy_en_d   = 1'b1;
        hdr_err    = 1'b0;
        len_err    = 1'b0;
        sl_in_vld  = 1'b0;
        sl_in_last = 1'b0;
        byte_idx   = (state_q == IDLE) ? 3'd0 : bcnt_q;
        hdr_vec    = hdr_q;

        // Header bytes land by position so byte 0 is the MSB of src_port.
        if (accept && (state_q == IDLE || state_q == HDR)) begin
            hdr_vec[(UDP_HDR_BYTES - 1 - int'(byte_idx)) * 8 +: 8] = s_axis_tdata;
            hdr_d  = udp_hdr_t'(hdr_vec);
            bcnt_d = byte_idx + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_axis_tlast) hdr_err = 1'b1;
                    else              state_d = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    if (bcnt_q == LAST_IDX) begin
                        state_d = HDR_OUT;
                        ended_d = s_axis_tlast;
                        if (s_axis_tlast && hdr_d.length > HDR_LEN) len_err = 1'b1;
                    end else if (s_axis_tlast) begin
                        hdr_err = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            HDR_OUT: begin
                if (m_udp_hdr_trdy) begin
                    pcnt_d  = (hdr_q.length >= HDR_LEN) ? hdr_q.length - HDR_LEN : 16'd0;
                    ended_d = 1'b0;
                    if (ended_q) begin
                        state_d = IDLE;
                    end else if (hdr_q.length < HDR_LEN) begin
                        len_err = 1'b1;
                        state_d = DRAIN;
                    end else if (hdr_q.length == HDR_LEN) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    sl_in_vld  = 1'b1;
                    sl_in_last = (pcnt_q == 16'd1) || s_axis_tlast;
                    pcnt_d     = pcnt_q - 16'd1;
                    // Bytes beyond the UDP length are link padding, discarded in DRAIN.
                    if (pcnt_q == 16'd1) begin
                        state_d = s_axis_tlast ? IDLE : DRAIN;
                    end else if (s_axis_tlast) begin
                        len_err = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            hdr_q    <= '0;
            bcnt_q   <= '0;
            pcnt_q   <= '0;
            ended_q  <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            bcnt_q   <= bcnt_d;
            pcnt_q   <= pcnt_d;
            ended_q  <= ended_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    assign m_udp_hdr_tvalid   = (state_q == HDR_OUT);
    assign m_udp_src_port     = hdr_q.src_port;
    assign m_udp_dst_port     = hdr_q.dst_port;
    assign m_udp_length       = hdr_q.length;
    assign m_udp_hdr_checksum = hdr_q.checksum;
    assign o_hdr_err          = hdr_err;
    assign o_len_err          = len_err;

endmodule

// File: tb/tb_udp_rx.sv
// Directed and random frames against a frame-level reference model of UDP de-encapsulation.
module tb_udp_rx;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_trdy;
    logic        m_udp_hdr_tvalid, m_udp_hdr_trdy;
    logic [15:0] m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_hdr_checksum;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_trdy;
    logic        o_hdr_err, o_len_err;

    always #5 i_clk = ~i_clk;

    udp_rx #(.AXI_DATA_WIDTH(8)) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_trdy        (s_axis_trdy),
        .m_udp_hdr_tvalid   (m_udp_hdr_tvalid),
        .m_udp_hdr_trdy     (m_udp_hdr_trdy),
        .m_udp_src_port     (m_udp_src_port),
        .m_udp_dst_port     (m_udp_dst_port),
        .m_udp_length       (m_udp_length),
        .m_udp_hdr_checksum (m_udp_hdr_checksum),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_trdy        (m_axis_trdy),
        .o_hdr_err          (o_hdr_err),
        .o_len_err          (o_len_err)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    logic [63:0] exp_hdr[$], got_hdr[$];
    logic [8:0]  exp_pay[$], got_pay[$];
    logic [7:0]  frm[$];
    int exp_len_err = 0, got_len_err = 0, exp_hdr_err = 0, got_hdr_err = 0;
    int stall_cycles = 0, exp_stalls = 0;
    bit rand_mrdy = 1'b0;
    int hdr_stall_left = 0;

    logic [63:0] cur_hdr;
    assign cur_hdr = {m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_hdr_checksum};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumer-side ready drivers
    initial begin
        m_axis_trdy    = 1'b1;
        m_udp_hdr_trdy = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            m_axis_trdy = rand_mrdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hdr_stall_left > 0 && m_udp_hdr_tvalid) begin
                m_udp_hdr_trdy = 1'b0;
                hdr_stall_left--;
            end else begin
                m_udp_hdr_trdy = 1'b1;
            end
        end
    end

    logic        hdr_held = 1'b0, pay_held = 1'b0;
    logic [63:0] hdr_snap;
    logic [8:0]  pay_snap;

    always @(negedge i_clk) begin
        if (i_reset) begin
            hdr_held = 1'b0;
            pay_held = 1'b0;
        end else begin
            if (hdr_held) begin
                chk("hdr_vld_held", 64'(m_udp_hdr_tvalid), 64'd1);
                chk("hdr_stable", cur_hdr, hdr_snap);
            end
            if (m_udp_hdr_tvalid) begin
                chk("in_rdy_in_hdr_out", 64'(s_axis_trdy), 64'd0);
                if (m_udp_hdr_trdy) begin
                    got_hdr.push_back(cur_hdr);
                    hdr_held = 1'b0;
                end else begin
                    hdr_snap = cur_hdr;
                    hdr_held = 1'b1;
                end
            end
            if (pay_held) begin
                chk("pay_vld_held", 64'(m_axis_tvalid), 64'd1);
                chk("pay_stable", 64'({m_axis_tlast, m_axis_tdata}), 64'(pay_snap));
            end
            pay_held = 1'b0;
            if (m_axis_tvalid) begin
                if (m_axis_trdy) begin
                    got_pay.push_back({m_axis_tlast, m_axis_tdata});
                end else begin
                    pay_snap = {m_axis_tlast, m_axis_tdata};
                    pay_held = 1'b1;
                end
            end
            if (o_len_err) got_len_err++;
            if (o_hdr_err) got_hdr_err++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        logic acc;
        s_axis_tdata  = b;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge i_clk);
            acc = s_axis_trdy;
            @(posedge i_clk);
            #1;
            if (acc) break;
            stall_cycles++;
            if (t > 1000) begin
                n_asserts++;
                n_fail++;
                $error("FAIL in_rdy_timeout: observed no acceptance expected acceptance");
                break;
            end
        end
    endtask

    task automatic mk_hdr(input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len, input logic [15:0] csum);
        frm.delete();
        frm.push_back(src[15:8]); frm.push_back(src[7:0]);
        frm.push_back(dst[15:8]); frm.push_back(dst[7:0]);
        frm.push_back(len[15:8]); frm.push_back(len[7:0]);
        frm.push_back(csum[15:8]); frm.push_back(csum[7:0]);
    endtask

    // Reference: what a UDP receiver must emit for the whole frame, then drive it.
    task automatic send_frame();
        int n, need, avail, k;
        logic [15:0] len;
        n = frm.size();
        if (n < 8) begin
            exp_hdr_err++;
        end else begin
            len = {frm[4], frm[5]};
            exp_hdr.push_back({frm[0], frm[1], frm[2], frm[3], frm[4], frm[5], frm[6], frm[7]});
            exp_stalls++;
            if (n == 8) begin
                if (len > 16'd8) exp_len_err++;
            end else if (len < 16'd8) begin
                exp_len_err++;
            end else if (len > 16'd8) begin
                need  = int'(len) - 8;
                avail = n - 8;
                k     = (avail < need) ? avail : need;
                for (int i = 0; i < k; i++) exp_pay.push_back({i == k - 1, frm[8 + i]});
                if (avail < need) exp_len_err++;
            end
        end
        for (int i = 0; i < n; i++) send_byte(frm[i], i == n - 1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int t = 0; t < 300; t++) begin
            if (got_hdr.size() >= exp_hdr.size() && got_pay.size() >= exp_pay.size() &&
                !m_axis_tvalid && !m_udp_hdr_tvalid) break;
            @(posedge i_clk);
            #1;
        end
        repeat (2) @(posedge i_clk);
        #1;
        chk({tag, "_hdr_count"}, 64'(got_hdr.size()), 64'(exp_hdr.size()));
        chk({tag, "_pay_count"}, 64'(got_pay.size()), 64'(exp_pay.size()));
        while (got_hdr.size() > 0 && exp_hdr.size() > 0)
            chk({tag, "_hdr"}, got_hdr.pop_front(), exp_hdr.pop_front());
        while (got_pay.size() > 0 && exp_pay.size() > 0)
            chk({tag, "_pay"}, 64'(got_pay.pop_front()), 64'(exp_pay.pop_front()));
        chk({tag, "_len_err"}, 64'(got_len_err), 64'(exp_len_err));
        chk({tag, "_hdr_err"}, 64'(got_hdr_err), 64'(exp_hdr_err));
        got_hdr.delete(); exp_hdr.delete(); got_pay.delete(); exp_pay.delete();
        got_len_err = 0; exp_len_err = 0; got_hdr_err = 0; exp_hdr_err = 0;
    endtask

    initial begin
        int r, p, avail;
        logic [15:0] len;
        i_reset       = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_outputs", 64'({s_axis_trdy, m_udp_hdr_tvalid, m_axis_tvalid, m_axis_tlast,
                                o_hdr_err, o_len_err}), 64'd0);
        chk("rst_fields", cur_hdr, 64'd0);
        chk("rst_pay_data", 64'(m_axis_tdata), 64'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("rdy_first_cycle", 64'(s_axis_trdy), 64'd0);
        @(negedge i_clk);
        chk("rdy_after_reset", 64'(s_axis_trdy), 64'd1);
        @(posedge i_clk);
        #1;

        // Reset in the middle of a header drops it; the next frame parses from byte 0
        mk_hdr(16'hCAFE, 16'hF00D, 16'h0010, 16'h0000);
        for (int i = 0; i < 3; i++) send_byte(frm[i], 1'b0);
        s_axis_tvalid = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_hdr_vld", 64'(m_udp_hdr_tvalid), 64'd0);
        @(posedge i_clk);
        #1;

        mk_hdr(16'h1234, 16'h5678, 16'h000C, 16'hABCD);
        frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
        send_frame();
        check_all("basic");

        hdr_stall_left = 10;
        rand_mrdy      = 1'b1;
        mk_hdr(16'h1234, 16'h5678, 16'h000C, 16'hABCD);
        frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
        send_frame();
        check_all("stall");
        rand_mrdy = 1'b0;

        mk_hdr(16'h0A0B, 16'h0C0D, 16'h000A, 16'h1111);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'h40 + i));
        send_frame();
        check_all("padding");

        mk_hdr(16'h2222, 16'h3333, 16'h0014, 16'h4444);
        for (int i = 0; i < 4; i++) frm.push_back(8'(8'h90 + i));
        send_frame();
        check_all("short");

        mk_hdr(16'h5555, 16'h6666, 16'h000C, 16'h7777);
        while (frm.size() > 6) void'(frm.pop_back());
        send_frame();
        mk_hdr(16'h8888, 16'h9999, 16'h000B, 16'hAAAA);
        for (int i = 0; i < 3; i++) frm.push_back(8'(8'hC0 + i));
        send_frame();
        check_all("hdr_trunc");

        mk_hdr(16'h0101, 16'h0202, 16'h0008, 16'h0303);
        send_frame();
        check_all("zero_len");

        stall_cycles = 0;
        exp_stalls   = 0;
        for (int f = 0; f < 100; f++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                frm.delete();
                p = $urandom_range(1, 7);
                for (int i = 0; i < p; i++) frm.push_back(8'($urandom));
            end else begin
                p     = $urandom_range(0, 20);
                len   = (r == 1) ? 16'($urandom_range(0, 7)) : 16'(p + 8);
                avail = (r == 1) ? $urandom_range(0, 4)
                      : (r == 2) ? $urandom_range(0, p) : p + $urandom_range(0, 3);
                mk_hdr(16'($urandom), 16'($urandom), len, 16'($urandom));
                for (int i = 0; i < avail; i++) frm.push_back(8'($urandom));
            end
            send_frame();
        end
        chk("b2b_stall_cycles", 64'(stall_cycles), 64'(exp_stalls));
        check_all("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
